// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 core: vector geometry, vector opcodes
// and the load/store burst sequencer state encoding.
package cvp14_pkg;

    localparam int NELEM = 16;
    localparam int IDXW  = 4;
    localparam int DW    = 16;

    localparam logic [3:0] OP_VLD = 4'b0100;
    localparam logic [3:0] OP_VST = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } burst_state_e;

    function automatic logic is_vls_op(input logic [3:0] op);
        return (op == OP_VLD) || (op == OP_VST);
    endfunction

endpackage

// File: rtl/vls_addr_gen.sv
// Element address and index generator for a vector load/store burst.
// The address wraps modulo 2^AW and the index wraps modulo NELEM.
module vls_addr_gen #(
    parameter int NELEM = cvp14_pkg::NELEM,
    parameter int IDXW  = cvp14_pkg::IDXW,
    parameter int AW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            inc,
    input  logic [AW-1:0]   base,
    input  logic [5:0]      imm,
    output logic [AW-1:0]   addr,
    output logic [IDXW-1:0] idx,
    output logic            last
);
    import cvp14_pkg::*;

    logic [AW-1:0]   addr_q, addr_d;
    logic [IDXW-1:0] idx_q, idx_d;

    always_comb begin
        addr_d = addr_q;
        idx_d  = idx_q;
        if (load) begin
            addr_d = base + AW'(imm);
            idx_d  = '0;
        end else if (inc) begin
            addr_d = addr_q + AW'(1);
            idx_d  = idx_q + IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            idx_q  <= '0;
        end else begin
            addr_q <= addr_d;
            idx_q  <= idx_d;
        end
    end

    assign addr = addr_q;
    assign idx  = idx_q;
    assign last = (idx_q == IDXW'(NELEM - 1));

endmodule

// File: rtl/vls_burst_ctrl.sv
// Vector load/store burst sequencer: one memory request per element, load
// data written back to the vector file one cycle later, done/err to the core.
module vls_burst_ctrl #(
    parameter int NELEM = cvp14_pkg::NELEM,
    parameter int IDXW  = cvp14_pkg::IDXW,
    parameter int AW    = 16,
    parameter int DW    = cvp14_pkg::DW,
    parameter int TMO   = 255
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start,
    input  logic            isStore,
    input  logic [AW-1:0]   base,
    input  logic [5:0]      imm,
    output logic [AW-1:0]   Addr,
    output logic            RD,
    output logic            WR,
    output logic [DW-1:0]   DataOut,
    input  logic [DW-1:0]   DataIn,
    input  logic            memRdy,
    output logic [IDXW-1:0] elemIdx,
    output logic            vRD_s,
    input  logic [DW-1:0]   vOutS,
    output logic            vWR_s,
    output logic [IDXW-1:0] vWIdx,
    output logic [DW-1:0]   vData_s,
    output logic            busy,
    output logic            done,
    output logic            err
);
    import cvp14_pkg::*;

    localparam int TW = $clog2(TMO + 1);

    burst_state_e    state_q, state_d;
    logic            st_q, st_d;
    logic [TW-1:0]   tmo_q, tmo_d, tmo_inc;
    logic            err_q, err_d;
    logic            vwr_q, vwr_d;
    logic [IDXW-1:0] vwidx_q, vwidx_d;
    logic [DW-1:0]   vdata_q, vdata_d;

    logic            ag_load, ag_inc, ag_last;
    logic [AW-1:0]   ag_addr;
    logic [IDXW-1:0] ag_idx;
    logic            in_req, handshake;

    vls_addr_gen #(
        .NELEM (NELEM),
        .IDXW  (IDXW),
        .AW    (AW)
    ) u_addr_gen (
        .clk  (Clk),
        .rst  (Reset),
        .load (ag_load),
        .inc  (ag_inc),
        .base (base),
        .imm  (imm),
        .addr (ag_addr),
        .idx  (ag_idx),
        .last (ag_last)
    );

    assign in_req    = (state_q == REQ);
    assign handshake = in_req && memRdy;
    assign tmo_inc   = tmo_q + TW'(1);

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        ag_load = 1'b0;
        ag_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    st_d    = isStore;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    ag_load = 1'b1;
                end
            end
            REQ: begin
                if (memRdy) begin
                    ag_inc = 1'b1;
                    tmo_d  = '0;
                    if (ag_last) state_d = DONE;
                end else begin
                    tmo_d = tmo_inc;
                    // Stalled too long: abandon the remaining elements.
                    if (tmo_inc == TW'(TMO)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load data is captured on the handshake and written back one cycle later.
    always_comb begin
        vwr_d   = handshake && !st_q;
        vwidx_d = ag_idx;
        vdata_d = vdata_q;
        if (handshake && !st_q) vdata_d = DataIn;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            st_q    <= 1'b0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            vwr_q   <= 1'b0;
            vwidx_q <= '0;
            vdata_q <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            vwr_q   <= vwr_d;
            vwidx_q <= vwidx_d;
            vdata_q <= vdata_d;
        end
    end

    assign Addr    = in_req ? ag_addr : '0;
    assign RD      = in_req && !st_q;
    assign WR      = in_req && st_q;
    assign elemIdx = in_req ? ag_idx : '0;
    assign vRD_s   = in_req && st_q;
    assign DataOut = (in_req && st_q) ? vOutS : '0;
    assign busy    = in_req;
    assign done    = (state_q == DONE);
    assign err     = (state_q == DONE) && err_q;
    assign vWR_s   = vwr_q;
    assign vWIdx   = vwidx_q;
    assign vData_s = vdata_q;

endmodule

// File: tb/tb_vls_burst_ctrl.sv
// Directed bench for vls_burst_ctrl: load, store, stall, address wrap,
// timeout and mid-burst reset, with a simple combinational memory/vector-file model.
module tb_vls_burst_ctrl;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [15:0] base_i;
    logic [5:0]  imm_i;
    logic [15:0] addr;
    logic        rd, wr;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        mem_rdy;
    logic [3:0]  elem_idx;
    logic        vrd_s;
    logic [15:0] v_out_s;
    logic        vwr_s;
    logic [3:0]  vw_idx;
    logic [15:0] vdata_s;
    logic        busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign data_in = 16'hA000 + {12'h000, addr[3:0]};
    assign v_out_s = 16'h5500 + {12'h000, elem_idx};

    vls_burst_ctrl #(.TMO(TMO)) dut (
        .Clk     (clk),
        .Reset   (rst),
        .start   (start),
        .isStore (is_store),
        .base    (base_i),
        .imm     (imm_i),
        .Addr    (addr),
        .RD      (rd),
        .WR      (wr),
        .DataOut (data_out),
        .DataIn  (data_in),
        .memRdy  (mem_rdy),
        .elemIdx (elem_idx),
        .vRD_s   (vrd_s),
        .vOutS   (v_out_s),
        .vWR_s   (vwr_s),
        .vWIdx   (vw_idx),
        .vData_s (vdata_s),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, ".addr"}, 32'(addr), 32'h0);
        chk({nm, ".rd"}, 32'(rd), 32'h0);
        chk({nm, ".wr"}, 32'(wr), 32'h0);
        chk({nm, ".vwr"}, 32'(vwr_s), 32'h0);
        chk({nm, ".busy"}, 32'(busy), 32'h0);
        chk({nm, ".done"}, 32'(done), 32'h0);
        chk({nm, ".err"}, 32'(err), 32'h0);
    endtask

    // Runs one burst; cycle 1 is the first cycle after the start edge.
    task automatic run_burst(input string nm, input logic [15:0] b, input logic [5:0] im,
                             input logic store, input int stall_idx, input int stall_len,
                             input int abort_idx, input bit hold_start, input int exp_cycles,
                             input logic exp_err, input int exp_writes);
        logic [15:0] a0, ea;
        int e, sc, stalls, writes, pe, cyc;
        bit prev_hs, fin;
        a0 = b + {10'd0, im};
        e = 0; sc = 0; stalls = 0; writes = 0; pe = 0; cyc = 1;
        prev_hs = 1'b0; fin = 1'b0;
        base_i = b; imm_i = im; is_store = store; start = 1'b1;
        mem_rdy = !(stall_idx == 0 && stall_len > 0);
        tick();
        if (hold_start) is_store = !store;
        else start = 1'b0;
        while (!fin && cyc <= 400) begin
            chk({nm, ".vwr"}, 32'(vwr_s), 32'(prev_hs));
            if (prev_hs) begin
                ea = a0 + 16'(pe);
                chk({nm, ".vwidx"}, 32'(vw_idx), 32'(pe));
                chk({nm, ".vdata"}, 32'(vdata_s), 32'(16'hA000 + {12'h000, ea[3:0]}));
            end
            if (vwr_s) writes++;
            if (done) begin
                chk({nm, ".done_cycle"}, 32'(cyc), 32'(exp_cycles));
                chk({nm, ".err"}, 32'(err), 32'(exp_err));
                chk({nm, ".busy_done"}, 32'(busy), 32'h0);
                chk({nm, ".strobes_done"}, 32'({rd, wr}), 32'h0);
                chk({nm, ".writes"}, 32'(writes), 32'(exp_writes));
                if (exp_err) chk({nm, ".stall_cycles"}, 32'(stalls), 32'(TMO));
                start = 1'b0;
                fin = 1'b1;
            end else if (e == abort_idx) begin
                mem_rdy = 1'b1;
                rst = 1'b1;
                tick();
                chk_quiet({nm, ".rst"});
                rst = 1'b0;
                mem_rdy = 1'b0;
                return;
            end else begin
                ea = a0 + 16'(e);
                chk({nm, ".busy"}, 32'(busy), 32'h1);
                chk({nm, ".addr"}, 32'(addr), 32'(ea));
                chk({nm, ".rd"}, 32'(rd), 32'(!store));
                chk({nm, ".wr"}, 32'(wr), 32'(store));
                chk({nm, ".elem_idx"}, 32'(elem_idx), 32'(e));
                chk({nm, ".vrd"}, 32'(vrd_s), 32'(store));
                chk({nm, ".dout"}, 32'(data_out), store ? 32'h5500 + 32'(e) : 32'h0);
                chk({nm, ".done_low"}, 32'(done), 32'h0);
                if (e == stall_idx && sc < stall_len) begin
                    mem_rdy = 1'b0;
                    sc++;
                    stalls++;
                    prev_hs = 1'b0;
                end else begin
                    mem_rdy = 1'b1;
                    prev_hs = !store;
                    pe = e;
                    e++;
                end
                tick();
                cyc++;
            end
        end
        if (!fin) chk({nm, ".done_seen"}, 32'h0, 32'h1);
        mem_rdy = 1'b0;
        tick();
        chk_quiet({nm, ".after"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0;
        base_i = '0; imm_i = '0; mem_rdy = 1'b0;
        repeat (3) tick();
        chk_quiet("reset");
        chk("reset.elem_idx", 32'(elem_idx), 32'h0);
        chk("reset.dout", 32'(data_out), 32'h0);
        chk("reset.vwidx", 32'(vw_idx), 32'h0);
        chk("reset.vdata", 32'(vdata_s), 32'h0);
        rst = 1'b0;
        tick();
        chk("idle.busy", 32'(busy), 32'h0);

        run_burst("vld",     16'h0100, 6'd3,  1'b0, -1, 0,      -1, 1'b1, 17,          1'b0, 16);
        run_burst("vst",     16'h2000, 6'd10, 1'b1, -1, 0,      -1, 1'b1, 17,          1'b0, 0);
        run_burst("stall",   16'h0300, 6'd0,  1'b0,  5, 3,      -1, 1'b0, 20,          1'b0, 16);
        run_burst("wrap",    16'hFFF8, 6'h04, 1'b0, -1, 0,      -1, 1'b0, 17,          1'b0, 16);
        run_burst("tmo",     16'h0400, 6'd1,  1'b0,  3, 100000, -1, 1'b0, 3 + TMO + 1, 1'b1, 3);
        run_burst("abort",   16'h0500, 6'd2,  1'b0, -1, 0,       7, 1'b0, 0,           1'b0, 0);
        run_burst("restart", 16'h0500, 6'd2,  1'b0, -1, 0,      -1, 1'b0, 17,          1'b0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
